// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int QUEUE_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Wraps naturally at 2^32 because the result is truncated to 32 bits.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] addr);
        return addr + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-entry {pc, instr} FIFO; slot0 is always the head
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_entry_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t slot0_q, slot0_d;
    fetch_entry_t slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'(QUEUE_DEPTH));
    assign head_o  = slot0_q;

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Shift organisation keeps the head in a fixed slot, so it never moves unless popped.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (push_ok && pop_ok) begin
            if (count_q == 2'd1) begin
                slot0_d = push_entry_i;
            end else begin
                slot0_d = slot1_q;
                slot1_d = push_entry_i;
            end
        end else if (pop_ok) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end else if (push_ok) begin
            if (count_q == 2'd0) begin
                slot0_d = push_entry_i;
            end else begin
                slot1_d = push_entry_i;
            end
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, redirect handling and fetch queue feed
// Optional out-of-range fetch fault is enabled by defining FETCH_RANGE_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    if (IMEM_WORDS < 1) begin : g_bad_imem_words
        $error("IMEM_WORDS must be at least 1");
    end

    logic [31:0]  pc_q, pc_d;
    logic         q_full;
    logic         q_empty;
    logic         pop;
    logic         push;
    logic         fetch_ok;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign imem_addr = pc_q;

`ifdef FETCH_RANGE_CHECK_EN
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS * INSTR_BYTES);

    logic fault_q, fault_d;
    logic pc_in_range;

    assign pc_in_range = ({1'b0, pc_q} < IMEM_LIMIT);
    assign fetch_ok    = !fault_q && pc_in_range;
    assign fault       = fault_q;

    // Redirect is the only way out of a fault besides reset.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = 1'b0;
        end else if (!pc_in_range) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign fetch_ok = 1'b1;
    assign fault    = 1'b0;
`endif

    assign out_valid = !q_empty;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

    assign pop  = out_valid && out_ready;
    assign push = !redirect_valid && fetch_ok && (!q_full || pop);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_rd;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = next_seq_pc(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue u_queue (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .push_entry_i (push_entry),
        .head_o       (head_entry),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the byte address fetched first after reset.
REQ-002 Parameter IMEM_WORDS, default 64, SHALL be the instruction memory depth in 32-bit words.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  byte address driven to the instruction memory; equals the current PC.
REQ-006 imem_rd  input  32  instruction word returned combinationally by the memory for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 out_valid  output  1  head of queue holds a valid instruction.
REQ-010 out_ready  input  1  decode accepts the head entry.
REQ-011 out_instr  output  32  instruction at queue head.
REQ-012 out_pc  output  32  byte address of out_instr.
REQ-013 fault  output  1  sticky out-of-range fetch flag; SHALL be tied 0 when FETCH_RANGE_CHECK_EN is undefined.

Function
REQ-014 PC register SHALL drive imem_addr directly, with no register between PC and imem_addr.
REQ-015 Queue SHALL be a 2-entry FIFO of {pc, instr}; out_* SHALL reflect the head entry.
REQ-016 Pop SHALL occur when out_valid && out_ready.
REQ-017 Push of {PC, imem_rd} SHALL occur when there is no redirect, fault is 0, and (count < 2 or a pop occurs in the same cycle).
REQ-018 On push, PC SHALL become PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 With no push, PC SHALL hold.
REQ-020 Redirect SHALL take priority: queue emptied, PC <= {redirect_pc[31:2], 2'b00}, no push that cycle; a pop in the same cycle counts as completed.
REQ-021 out_valid SHALL be 0 in the cycle after a redirect; the target instruction SHALL be valid one cycle after that.
REQ-022 Latency: an instruction pushed at edge N SHALL be visible on out_* at cycle N+1 when the queue was empty.
REQ-023 Full queue with out_ready=1 SHALL sustain one instruction per cycle with no bubble.
REQ-024 out_instr and out_pc SHALL hold stable while out_valid && !out_ready.

Reset
REQ-025 On reset: PC=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fault=0.
REQ-026 Reset SHALL override a simultaneous redirect, push, or pop; in-flight queue contents SHALL be discarded.
REQ-027 The first push SHALL occur at the first edge with reset low.

Configuration
REQ-028 Macro FETCH_RANGE_CHECK_EN defined: when PC >= IMEM_WORDS*4 and no redirect, fault SHALL set (sticky) and pushes SHALL stop; already-queued entries SHALL still drain.
REQ-029 With FETCH_RANGE_CHECK_EN defined, fault SHALL clear on reset or on a redirect.
REQ-030 Macro FETCH_RANGE_CHECK_EN undefined: no range logic, fault constant 0, and fetching continues at any address.

Structure
REQ-031 Package fetch_pkg SHALL hold typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;} and constant INSTR_BYTES = 4.
REQ-032 The 2-entry FIFO SHALL be sub-module fetch_queue (push/pop/flush, full/empty, head entry out); all other logic lives in fetch_unit.

Verification
REQ-033 Reset release, memory word0=32'hE3A0_0001 and word1=32'hE3A0_1002, out_ready=1 -> cycle 1: out_pc=0, out_instr=E3A00001; cycle 2: out_pc=4, out_instr=E3A01002.
REQ-034 out_ready=0 for 5 cycles -> count saturates at 2, PC=8, out_pc stays 0; then out_ready=1 -> pc 0, 4, 8 delivered on consecutive cycles.
REQ-035 Redirect to 32'h0000_0032 while queue is full -> next cycle out_valid=0, PC=0x30; following cycle out_pc=0x30.
REQ-036 Redirect and pop in the same cycle -> popped entry is not re-delivered and the queue is empty afterwards.
REQ-037 FETCH_RANGE_CHECK_EN defined, IMEM_WORDS=4, out_ready=1 -> pcs 0..0xC delivered, fault=1 when PC=0x10, out_valid=0 afterwards; redirect to 0 clears fault.
REQ-038 Reset asserted mid-stream with count=2 -> next cycle out_valid=0 and PC=RESET_PC.
